// File: rtl/lzrw1_stream_compressor_if.sv
// Byte-in / token-out stream bundle for the LZRW1 block compressor.
interface lzrw1_stream_compressor_if #(
    parameter int unsigned PTR_W = 12
);
    logic             in_valid;
    logic [7:0]       in_byte;
    logic             in_last;
    logic             in_ready;
    logic             tok_valid;
    logic             tok_ready;
    logic             tok_is_copy;
    logic [7:0]       tok_literal;
    logic [PTR_W-1:0] tok_offset;
    logic [4:0]       tok_length;
    logic             tok_group_end;
    logic             tok_last;
    logic             done;

    modport master (
        output in_valid, in_byte, in_last, tok_ready,
        input  in_ready, tok_valid, tok_is_copy, tok_literal, tok_offset,
               tok_length, tok_group_end, tok_last, done
    );

    modport slave (
        input  in_valid, in_byte, in_last, tok_ready,
        output in_ready, tok_valid, tok_is_copy, tok_literal, tok_offset,
               tok_length, tok_group_end, tok_last, done
    );
endinterface

// File: rtl/lzrw1_stream_compressor.sv
// LZRW1-style block compressor: buffers one block, then emits literal/copy
// tokens found through a single-probe hash of the next three bytes.
module lzrw1_stream_compressor #(
    parameter int unsigned BLOCK_BYTES  = 4096,
    parameter int unsigned HASH_ENTRIES = 4096,
    parameter int unsigned MAX_MATCH    = 18,
    localparam int unsigned PTR_W  = $clog2(BLOCK_BYTES),
    localparam int unsigned HASH_W = $clog2(HASH_ENTRIES)
) (
    input logic                     clock,
    input logic                     reset,
    lzrw1_stream_compressor_if.slave bus
);
    typedef enum logic [2:0] {LOAD, LOOKUP, MATCH, EMIT, DONE} state_t;

    localparam logic [4:0]       MAX_LEN   = 5'(MAX_MATCH);
    localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(BLOCK_BYTES - 1);

    state_t state, state_next;

    logic [7:0]              data_mem [BLOCK_BYTES];
    logic [PTR_W-1:0]        hash_tab [HASH_ENTRIES];
    logic [HASH_ENTRIES-1:0] hash_vld;

    logic [PTR_W-1:0] wr_ptr, cand, p0;
    logic [PTR_W:0]   count, pos, pos_len, remain, adv;
    logic [4:0]       len;
    logic [3:0]       grp;
    logic [23:0]      hkey;
    logic [HASH_W-1:0] hidx;
    logic             has3, hit, match_more;
    logic             accept_byte, close_block, accept_tok;

    logic             tok_copy, tok_end;
    logic [7:0]       tok_lit;
    logic [PTR_W-1:0] tok_off;
    logic [4:0]       tok_len;

    always_comb begin
        p0         = pos[PTR_W-1:0];
        remain     = count - pos;
        has3       = remain >= (PTR_W+1)'(3);
        hkey       = {data_mem[p0], data_mem[p0 + PTR_W'(1)], data_mem[p0 + PTR_W'(2)]};
        hidx       = HASH_W'(hkey ^ (hkey >> HASH_W));
        hit        = has3 && hash_vld[hidx];
        pos_len    = pos + (PTR_W+1)'(len);
        match_more = (pos_len < count) && (len < MAX_LEN)
                     && (data_mem[cand + PTR_W'(len)] == data_mem[pos_len[PTR_W-1:0]]);
        adv        = tok_copy ? (PTR_W+1)'(tok_len) : (PTR_W+1)'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= LOAD;
        else       state <= state_next;
    end

    // Handshake outputs are gated by reset so nothing is offered while it is held.
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.tok_valid = 1'b0;
        bus.done      = 1'b0;
        accept_byte   = 1'b0;
        close_block   = 1'b0;
        accept_tok    = 1'b0;
        case (state)
            LOAD: begin
                bus.in_ready = !reset;
                accept_byte  = bus.in_valid && !reset;
                close_block  = accept_byte && (bus.in_last || wr_ptr == LAST_ADDR);
                if (close_block) state_next = LOOKUP;
            end
            LOOKUP: state_next = hit ? MATCH : EMIT;
            MATCH:  if (!match_more) state_next = EMIT;
            EMIT: begin
                bus.tok_valid = !reset;
                accept_tok    = bus.tok_ready && !reset;
                if (accept_tok) state_next = tok_end ? DONE : LOOKUP;
            end
            DONE: begin
                bus.done   = !reset;
                state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (accept_byte) data_mem[wr_ptr] <= bus.in_byte;
        if (state == LOOKUP && has3) hash_tab[hidx] <= p0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            count    <= '0;
            pos      <= '0;
            grp      <= '0;
            hash_vld <= '0;
            cand     <= '0;
            len      <= '0;
            tok_copy <= 1'b0;
            tok_end  <= 1'b0;
            tok_lit  <= '0;
            tok_off  <= '0;
            tok_len  <= '0;
        end else begin
            case (state)
                LOAD: if (accept_byte) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (close_block) begin
                        count    <= {1'b0, wr_ptr} + 1'b1;
                        pos      <= '0;
                        grp      <= '0;
                        hash_vld <= '0;
                    end
                end
                LOOKUP: begin
                    if (has3) hash_vld[hidx] <= 1'b1;
                    cand <= hash_tab[hidx];
                    len  <= '0;
                    if (!hit) begin
                        tok_copy <= 1'b0;
                        tok_lit  <= data_mem[p0];
                        tok_off  <= '0;
                        tok_len  <= '0;
                        tok_end  <= (pos + 1'b1) == count;
                    end
                end
                MATCH: begin
                    if (match_more) begin
                        len <= len + 1'b1;
                    end else if (len >= 5'd3) begin
                        tok_copy <= 1'b1;
                        tok_lit  <= '0;
                        tok_off  <= p0 - cand;
                        tok_len  <= len;
                        tok_end  <= pos_len == count;
                    end else begin
                        tok_copy <= 1'b0;
                        tok_lit  <= data_mem[p0];
                        tok_off  <= '0;
                        tok_len  <= '0;
                        tok_end  <= (pos + 1'b1) == count;
                    end
                end
                EMIT: if (accept_tok) begin
                    pos <= pos + adv;
                    grp <= grp + 1'b1;
                end
                DONE: wr_ptr <= '0;
                default: ;
            endcase
        end
    end

    assign bus.tok_is_copy   = bus.tok_valid & tok_copy;
    assign bus.tok_literal   = bus.tok_valid ? tok_lit : '0;
    assign bus.tok_offset    = bus.tok_valid ? tok_off : '0;
    assign bus.tok_length    = bus.tok_valid ? tok_len : '0;
    assign bus.tok_last      = bus.tok_valid & tok_end;
    assign bus.tok_group_end = bus.tok_valid & ((grp == 4'hF) | tok_end);
endmodule

// File: tb/tb_lzrw1_stream_compressor.sv
// Self-checking bench: directed block scenarios plus randomized blocks checked
// against a queue-based model of the compression rules.
module tb_lzrw1_stream_compressor;
    localparam int BB = 64;
    localparam int HE = 256;
    localparam int HW = 8;
    localparam int MM = 18;
    localparam int PW = 6;

    typedef struct packed {
        logic          is_copy;
        logic [7:0]    lit;
        logic [PW-1:0] off;
        logic [4:0]    len;
        logic          ge;
        logic          last;
    } tok_t;
    typedef logic [7:0] bq_t[$];
    typedef tok_t tq_t[$];

    logic clock = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    lzrw1_stream_compressor_if #(.PTR_W(PW)) bus ();

    lzrw1_stream_compressor #(
        .BLOCK_BYTES(BB),
        .HASH_ENTRIES(HE),
        .MAX_MATCH(MM)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic tok_t mk(bit c, logic [7:0] l, int o, int n, bit ge, bit last);
        tok_t t;
        t.is_copy = c; t.lit = l; t.off = PW'(o); t.len = 5'(n); t.ge = ge; t.last = last;
        return t;
    endfunction

    // Reference: greedy LZRW1 walk with an associative hash table.
    function automatic tq_t model(input bq_t d);
        tq_t q;
        int tab[int];
        int n, pos, cand, len, adv, x, h;
        tok_t t;
        n = d.size();
        pos = 0;
        while (pos < n) begin
            cand = -1; len = 0; adv = 1; t = '0;
            if (n - pos >= 3) begin
                x = (int'(d[pos]) << 16) | (int'(d[pos+1]) << 8) | int'(d[pos+2]);
                h = (x ^ (x >> HW)) % HE;
                if (tab.exists(h)) cand = tab[h];
                tab[h] = pos;
            end
            if (cand >= 0)
                while (pos + len < n && len < MM && d[cand+len] == d[pos+len]) len++;
            if (len >= 3) begin
                t.is_copy = 1'b1; t.off = PW'(pos - cand); t.len = 5'(len); adv = len;
            end else begin
                t.lit = d[pos];
            end
            t.last = (pos + adv == n);
            t.ge = (q.size() % 16 == 15) || t.last;
            q.push_back(t);
            pos += adv;
        end
        return q;
    endfunction

    function automatic tok_t sample();
        return {bus.tok_is_copy, bus.tok_literal, bus.tok_offset, bus.tok_length,
                bus.tok_group_end, bus.tok_last};
    endfunction

    task automatic load_block(input bq_t d, input bit use_last, input bit gaps);
        int b;
        for (int i = 0; i < d.size(); i++) begin
            if (gaps)
                while ($urandom_range(0, 2) == 0) begin
                    bus.in_valid = 1'b0;
                    @(negedge clock);
                end
            bus.in_valid = 1'b1;
            bus.in_byte  = d[i];
            bus.in_last  = use_last && (i == d.size() - 1);
            b = 200;
            while (!bus.in_ready && b > 0) begin
                @(negedge clock);
                b--;
            end
            if (!bus.in_ready) begin
                vectors++; miscompares++;
                $display("FAIL load_timeout byte=%0d in_ready=0 required=1", i);
            end
            @(negedge clock);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic collect(input int stall, input bit rnd, output tq_t got,
                           output int dc, output int un, output int ov, output bit to);
        tok_t cur, held;
        bit have, fin;
        int wc, budget;
        have = 0; fin = 0; wc = 0; budget = 3000;
        got.delete(); dc = 0; un = 0; ov = 0;
        bus.tok_ready = (stall == 0 && !rnd);
        while (!fin && budget > 0) begin
            @(negedge clock);
            budget--;
            if (bus.in_ready && bus.tok_valid) ov++;
            if (bus.done) dc++;
            if (bus.tok_valid) begin
                cur = sample();
                if (have && cur !== held) un++;
                held = cur; have = 1;
                if (stall > 0)  bus.tok_ready = (wc >= stall);
                else if (rnd)   bus.tok_ready = 1'($urandom_range(0, 1));
                else            bus.tok_ready = 1'b1;
                if (bus.tok_ready) begin
                    got.push_back(cur); have = 0; wc = 0; fin = cur.last;
                end else begin
                    wc++;
                end
            end else if (rnd) begin
                bus.tok_ready = 1'($urandom_range(0, 1));
            end
        end
        to = !fin;
        repeat (3) begin
            @(negedge clock);
            bus.tok_ready = 1'b0;
            if (bus.in_ready && bus.tok_valid) ov++;
            if (bus.done) dc++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        vectors++; if (bus.tok_valid !== 1'b0) begin miscompares++; $display("FAIL rst_tok_valid got=%b exp=0", bus.tok_valid); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL rst_done got=%b exp=0", bus.done); end
        reset = 1'b0;
        @(negedge clock);
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_abc(input int stall, input string nm);
        bq_t d; tq_t got, exp; int dc, un, ov; bit to;
        for (int i = 0; i < 9; i++) d.push_back(8'h61 + 8'(i % 3));
        exp = '{mk(0, 8'h61, 0, 0, 0, 0), mk(0, 8'h62, 0, 0, 0, 0),
                mk(0, 8'h63, 0, 0, 0, 0), mk(1, 8'h00, 3, 6, 1, 1)};
        load_block(d, 1, 0);
        collect(stall, 0, got, dc, un, ov, to);
        vectors++; if (to || got.size() != exp.size()) begin miscompares++; $display("FAIL %s_count got=%0d exp=%0d", nm, got.size(), exp.size()); end
        foreach (exp[i]) if (i < got.size()) begin
            vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL %s_tok%0d got=%h exp=%h", nm, i, got[i], exp[i]); end
        end
        vectors++; if (dc != 1) begin miscompares++; $display("FAIL %s_done got=%0d exp=1", nm, dc); end
        vectors++; if (un != 0) begin miscompares++; $display("FAIL %s_stable got=%0d changes exp=0", nm, un); end
        vectors++; if (ov != 0) begin miscompares++; $display("FAIL %s_overlap got=%0d exp=0", nm, ov); end
    endtask

    task automatic test_run();
        bq_t d; tq_t got, exp; int dc, un, ov; bit to;
        repeat (20) d.push_back(8'h41);
        exp = '{mk(0, 8'h41, 0, 0, 0, 0), mk(1, 8'h00, 1, 18, 0, 0), mk(0, 8'h41, 0, 0, 1, 1)};
        load_block(d, 1, 0);
        collect(0, 0, got, dc, un, ov, to);
        vectors++; if (to || got.size() != exp.size()) begin miscompares++; $display("FAIL run_count got=%0d exp=%0d", got.size(), exp.size()); end
        foreach (exp[i]) if (i < got.size()) begin
            vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL run_tok%0d got=%h exp=%h", i, got[i], exp[i]); end
        end
        vectors++; if (dc != 1) begin miscompares++; $display("FAIL run_done got=%0d exp=1", dc); end
    endtask

    task automatic test_short();
        bq_t d; tq_t got, exp; int dc, un, ov; bit to;
        d = '{8'h10, 8'h20};
        exp = '{mk(0, 8'h10, 0, 0, 0, 0), mk(0, 8'h20, 0, 0, 1, 1)};
        load_block(d, 1, 0);
        collect(0, 0, got, dc, un, ov, to);
        vectors++; if (to || got.size() != exp.size()) begin miscompares++; $display("FAIL short_count got=%0d exp=%0d", got.size(), exp.size()); end
        foreach (exp[i]) if (i < got.size()) begin
            vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL short_tok%0d got=%h exp=%h", i, got[i], exp[i]); end
        end
        vectors++; if (dc != 1) begin miscompares++; $display("FAIL short_done got=%0d exp=1", dc); end
    endtask

    task automatic test_group();
        bq_t d; tq_t got, exp; int dc, un, ov; bit to;
        for (int i = 0; i < 17; i++) begin
            d.push_back(8'(i));
            exp.push_back(mk(0, 8'(i), 0, 0, (i >= 15), (i == 16)));
        end
        load_block(d, 1, 1);
        collect(0, 1, got, dc, un, ov, to);
        vectors++; if (to || got.size() != exp.size()) begin miscompares++; $display("FAIL group_count got=%0d exp=%0d", got.size(), exp.size()); end
        foreach (exp[i]) if (i < got.size()) begin
            vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL group_tok%0d got=%h exp=%h", i, got[i], exp[i]); end
        end
        vectors++; if (dc != 1) begin miscompares++; $display("FAIL group_done got=%0d exp=1", dc); end
    endtask

    task automatic test_random(input int nblocks, input bit full);
        bq_t d; tq_t got, exp; int dc, un, ov, n; bit to, ul;
        for (int b = 0; b < nblocks; b++) begin
            d.delete();
            n  = full ? BB : $urandom_range(1, BB);
            ul = (n < BB) ? 1'b1 : (full ? 1'b0 : 1'($urandom_range(0, 1)));
            for (int i = 0; i < n; i++) d.push_back(8'h61 + 8'($urandom_range(0, 3)));
            exp = model(d);
            load_block(d, ul, 1);
            collect(0, 1, got, dc, un, ov, to);
            vectors++; if (to || got.size() != exp.size()) begin miscompares++; $display("FAIL rnd%0d_count got=%0d exp=%0d", b, got.size(), exp.size()); end
            foreach (exp[i]) if (i < got.size()) begin
                vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL rnd%0d_tok%0d got=%h exp=%h", b, i, got[i], exp[i]); end
            end
            vectors++; if (dc != 1) begin miscompares++; $display("FAIL rnd%0d_done got=%0d exp=1", b, dc); end
            vectors++; if (un != 0 || ov != 0) begin miscompares++; $display("FAIL rnd%0d_protocol got=%0d/%0d exp=0/0", b, un, ov); end
        end
    endtask

    task automatic test_midload_reset();
        bq_t d;
        d = '{8'h78, 8'h79, 8'h7a};
        load_block(d, 0, 0);
        reset = 1'b1;
        @(negedge clock);
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL midload_in_ready got=%b exp=0", bus.in_ready); end
        reset = 1'b0;
        @(negedge clock);
        test_abc(0, "after_midload");
    endtask

    task automatic test_reset_in_match();
        bq_t d; tq_t got, exp; int dc, un, ov; bit to;
        repeat (20) d.push_back(8'h41);
        load_block(d, 1, 0);
        bus.tok_ready = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        bus.tok_ready = 1'b0;
        vectors++; if (bus.tok_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++; $display("FAIL match_rst_ctrl got=%b%b%b exp=000", bus.tok_valid, bus.in_ready, bus.done); end
        vectors++; if (sample() !== tok_t'(0)) begin miscompares++; $display("FAIL match_rst_fields got=%h exp=0", sample()); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL match_rst_release got=%b exp=1", bus.in_ready); end
        d.delete();
        for (int i = 0; i < 6; i++) d.push_back(8'h61 + 8'(i % 3));
        exp = '{mk(0, 8'h61, 0, 0, 0, 0), mk(0, 8'h62, 0, 0, 0, 0),
                mk(0, 8'h63, 0, 0, 0, 0), mk(1, 8'h00, 3, 3, 1, 1)};
        load_block(d, 1, 0);
        collect(0, 0, got, dc, un, ov, to);
        vectors++; if (to || got.size() != exp.size()) begin miscompares++; $display("FAIL post_rst_count got=%0d exp=%0d", got.size(), exp.size()); end
        foreach (exp[i]) if (i < got.size()) begin
            vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL post_rst_tok%0d got=%h exp=%h", i, got[i], exp[i]); end
        end
        vectors++; if (dc != 1) begin miscompares++; $display("FAIL post_rst_done got=%0d exp=1", dc); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_byte   = '0;
        bus.in_last   = 1'b0;
        bus.tok_ready = 1'b0;
        test_reset();
        test_abc(0, "abc");
        test_run();
        test_short();
        test_group();
        test_abc(5, "stall");
        test_random(2, 1'b1);
        test_midload_reset();
        test_reset_in_match();
        test_random(8, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
